// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM for a multicycle MIPS core. One shared ALU, one unified
// instruction/data memory and the register file are sequenced over several
// cycles per instruction. Memory accesses stall on mem_ready, undecodable
// instructions park the FSM in HALT (sticky illegal flag) and every completed
// instruction bumps the retired counter.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct       instruction fields from the instruction register
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory access completes this cycle
//   pc_en .. alu_ctrl   datapath enables and mux selects
//   illegal             sticky, set when an undecodable instruction is seen
//   retired             completed-instruction count, wraps at 2^CNT_W
//
// Build option
//   MIPS_MC_BNE_EN      when defined, opcode 000101 (bne) is decoded into a
//                       BNE state; otherwise it is treated as illegal.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 into PC when memory is ready
// DECODE | compute branch target into ALUOut, dispatch on opcode
// MEMADR | compute lw/sw effective address
// MEMRD  | load data word, wait for memory
// MEMWB  | write loaded word to rt
// MEMWR  | store word, wait for memory
// EXEC   | R-type ALU operation selected by funct
// ALUWB  | write ALU result to rd
// BRANCH | beq compare, PC <- target when equal
// BNE    | bne compare, PC <- target when not equal (build option)
// ADDIEX | addi: A + SignImm
// ADDIWB | write addi result to rt
// JUMP   | PC <- jump target
// HALT   | illegal instruction, exit only through rst

module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_HALT
`ifdef MIPS_MC_BNE_EN
    , S_BNE
`endif
  } state_t;

  state_t     state, state_next;
  logic       illegal_q;
  logic       retire;
  logic       funct_ok;
  logic [2:0] funct_ctrl;

  // R-type funct decode, shared by the EXEC outputs and the EXEC exit.
  always_comb begin
    funct_ok   = 1'b1;
    funct_ctrl = ALU_ADD;
    case (funct)
      6'b100000: funct_ctrl = ALU_ADD;
      6'b100010: funct_ctrl = ALU_SUB;
      6'b100100: funct_ctrl = ALU_AND;
      6'b100101: funct_ctrl = ALU_OR;
      6'b101010: funct_ctrl = ALU_SLT;
      default:   funct_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      retired   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (retire) retired <= retired + CNT_W'(1);
      if (state_next == S_HALT) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_next = S_BNE;
`endif
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      // A bad funct is caught here, before ALUWB, so nothing is written.
      S_EXEC:   state_next = funct_ok ? S_ALUWB : S_HALT;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MIPS_MC_BNE_EN
      S_BNE: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
`endif
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_ok ? funct_ctrl : ALU_ADD;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
`ifdef MIPS_MC_BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = ~zero;
      end
`endif
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // Keep the datapath and memory quiet while reset is held.
    if (rst) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
    end
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each instruction is expanded
// into the list of datapath actions it needs cycle by cycle (memory waits
// included) and every cycle's outputs are compared against that list.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 32;

  localparam logic [5:0] OP_RT   = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .retired(retired)
  );

  wire [16:0] dut_vec = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                         mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                         alu_ctrl, illegal};

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int rw_pulses = 0;
  logic [CNT_W-1:0] model_ret = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] v(input logic pe, io, mr, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] ac,
                                     input logic ill);
    return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ps, ac, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output vectors for each kind of cycle.
  function automatic logic [16:0] fetch_v(input logic r);
    return v(r, 0, 1, 0, r, 0, 0, 0, 0, 2'b01, 2'b00, ADD, 0);
  endfunction
  function automatic logic [16:0] exec_v(input logic [2:0] ac);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ac, 0);
  endfunction
  function automatic logic [16:0] branch_v(input logic take);
    return v(take, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, SUB, 0);
  endfunction
  wire [16:0] decode_v = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, ADD, 0);
  wire [16:0] adr_v    = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, ADD, 0);
  wire [16:0] memrd_v  = v(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 0);
  wire [16:0] memwb_v  = v(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, ADD, 0);
  wire [16:0] memwr_v  = v(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 0);
  wire [16:0] aluwb_v  = v(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, ADD, 0);
  wire [16:0] addiwb_v = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, ADD, 0);
  wire [16:0] jump_v   = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, ADD, 0);
  wire [16:0] halt_v   = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 1);
  wire [16:0] rstf_v   = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, ADD, 0);

  // R-type ALU op table; ok=0 for an undefined funct.
  function automatic logic [2:0] alu_of(input logic [5:0] fn, output logic ok);
    ok = 1'b1;
    case (fn)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
      default: begin ok = 1'b0; return ADD; end
    endcase
  endfunction

  // One clock cycle: drive inputs just after the rising edge, compare on the
  // falling edge, then advance.
  task automatic cyc(input logic rdy, input logic r, input logic [16:0] exp, input string nm);
    mem_ready = rdy;
    rst = r;
    @(negedge clk);
    check(nm, 64'(dut_vec), 64'(exp));
    cyc_cnt++;
    if (reg_write) rw_pulses++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = rb();
    @(posedge clk);
    #1;
    cyc(rb(), 1'b1, rstf_v, "reset_hold");
    check("reset_retired", 64'(retired), 64'd0);
    model_ret = '0;
    rst = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      zero = rb();
      funct = 6'($urandom_range(0, 63));
      cyc(rb(), 1'b0, halt_v, "halt");
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic z, output bit halted);
    logic ok;
    logic [2:0] ac;
    opcode = op;
    funct = fn;
    zero = z;
    halted = 0;
    check("retired", 64'(retired), 64'(model_ret));
    for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, fetch_v(1'b0), "fetch_wait");
    cyc(1'b1, 1'b0, fetch_v(1'b1), "fetch");
    cyc(rb(), 1'b0, decode_v, "decode");
    case (op)
      OP_LW: begin
        cyc(rb(), 1'b0, adr_v, "memadr");
        for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, memrd_v, "memrd_wait");
        cyc(1'b1, 1'b0, memrd_v, "memrd");
        cyc(rb(), 1'b0, memwb_v, "memwb");
        model_ret++;
      end
      OP_SW: begin
        cyc(rb(), 1'b0, adr_v, "memadr");
        for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, memwr_v, "memwr_wait");
        cyc(1'b1, 1'b0, memwr_v, "memwr");
        model_ret++;
      end
      OP_RT: begin
        ac = alu_of(fn, ok);
        cyc(rb(), 1'b0, exec_v(ac), "exec");
        if (ok) begin
          cyc(rb(), 1'b0, aluwb_v, "aluwb");
          model_ret++;
        end else halted = 1;
      end
      OP_BEQ: begin
        cyc(rb(), 1'b0, branch_v(z), "beq");
        model_ret++;
      end
`ifdef MIPS_MC_BNE_EN
      OP_BNE: begin
        cyc(rb(), 1'b0, branch_v(~z), "bne");
        model_ret++;
      end
`endif
      OP_ADDI: begin
        cyc(rb(), 1'b0, adr_v, "addiex");
        cyc(rb(), 1'b0, addiwb_v, "addiwb");
        model_ret++;
      end
      OP_J: begin
        cyc(rb(), 1'b0, jump_v, "jump");
        model_ret++;
      end
      default: halted = 1;
    endcase
  endtask

  initial begin
    bit h;
    logic [31:0] w;
    logic [5:0] legal_ops [7];
    legal_ops = '{OP_LW, OP_SW, OP_RT, OP_BEQ, OP_ADDI, OP_J, OP_BNE};

    do_reset();

    // addi: 4 cycles, retired becomes 1
    w = 32'h2010D08E;
    cyc_cnt = 0;
    run_instr(w[31:26], w[5:0], 0, 0, 1'b0, h);
    check("addi_cycles", 64'(cyc_cnt), 64'd4);
    check("addi_retired", 64'(retired), 64'd1);

    // lw with two wait cycles in MEMRD: 7 cycles, single write pulse
    w = 32'h8C100004;
    cyc_cnt = 0;
    rw_pulses = 0;
    run_instr(w[31:26], w[5:0], 0, 2, 1'b0, h);
    check("lw_cycles", 64'(cyc_cnt), 64'd7);
    check("lw_rw_pulses", 64'(rw_pulses), 64'd1);

    // R-type add, slt, then bad funct -> HALT
    w = 32'h02328020;
    cyc_cnt = 0;
    run_instr(w[31:26], w[5:0], 0, 0, 1'b0, h);
    check("add_cycles", 64'(cyc_cnt), 64'd4);
    run_instr(OP_RT, 6'h2A, 1, 0, 1'b0, h);
    rw_pulses = 0;
    run_instr(OP_RT, 6'h3F, 0, 0, 1'b0, h);
    check("badfunct_halted", 64'(h), 64'd1);
    halt_cycles(5);
    check("badfunct_illegal", 64'(illegal), 64'd1);
    check("badfunct_no_write", 64'(rw_pulses), 64'd0);
    do_reset();

    // beq taken and not taken, 3 cycles each
    w = 32'h12110002;
    cyc_cnt = 0;
    run_instr(w[31:26], w[5:0], 0, 0, 1'b1, h);
    check("beq_taken_cycles", 64'(cyc_cnt), 64'd3);
    cyc_cnt = 0;
    run_instr(w[31:26], w[5:0], 0, 0, 1'b0, h);
    check("beq_nt_cycles", 64'(cyc_cnt), 64'd3);

    // jump
    w = 32'h08000010;
    cyc_cnt = 0;
    run_instr(w[31:26], w[5:0], 0, 0, 1'b0, h);
    check("j_cycles", 64'(cyc_cnt), 64'd3);

    // sw aborted by reset in MEMADR
    opcode = OP_SW;
    funct = 6'h04;
    check("retired_pre_abort", 64'(retired), 64'(model_ret));
    cyc(1'b1, 1'b0, fetch_v(1'b1), "sw_fetch");
    cyc(1'b1, 1'b0, decode_v, "sw_decode");
    cyc(1'b1, 1'b1, adr_v, "sw_memadr_rst");
    model_ret = '0;
    check("abort_retired", 64'(retired), 64'd0);
    // sw aborted by reset in MEMWR while memory is ready: no strobe, no count
    run_instr(OP_ADDI, 6'h00, 0, 0, 1'b0, h);
    cyc(1'b1, 1'b0, fetch_v(1'b1), "sw2_fetch");
    opcode = OP_SW;
    cyc(1'b1, 1'b0, decode_v, "sw2_decode");
    cyc(1'b1, 1'b0, adr_v, "sw2_memadr");
    cyc(1'b1, 1'b1, v(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 0), "sw2_memwr_rst");
    model_ret = '0;
    check("abort2_retired", 64'(retired), 64'd0);

    // bne opcode with zero=0
    run_instr(OP_BNE, 6'h00, 0, 0, 1'b0, h);
`ifdef MIPS_MC_BNE_EN
    check("bne_decoded", 64'(h), 64'd0);
`else
    check("bne_halted", 64'(h), 64'd1);
    halt_cycles(2);
    check("bne_illegal", 64'(illegal), 64'd1);
    do_reset();
`endif

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
      else begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          default: fn = 6'h2A;
        endcase
      end
      run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb(), h);
      if (h) begin
        halt_cycles(3);
        do_reset();
      end
    end
    check("final_retired", 64'(retired), 64'(model_ret));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences a single shared ALU, a unified instruction/data memory and the register file across multiple clock cycles per instruction. It decodes opcode/funct from the instruction register and drives every datapath enable and mux select. It stalls on a memory-ready handshake, latches illegal instructions into a halt state, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_en`  out  1  PC register load enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = data register.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `pc_src`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alu_ctrl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  sticky; set on undecodable instruction.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- FETCH: `mem_read`=1, iord=0, src_a=0, src_b=01, add, pc_src=00. `ir_write`, PC write and the transition to DECODE are all gated by `mem_ready`; otherwise stay in FETCH.
- DECODE: src_a=0, src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 / 101011 → MEMADR.
  - 000000 → EXEC.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - else → HALT.
- MEMADR: src_a=1, src_b=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Stays until `mem_ready`, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
- MEMWR: iord=1, `mem_write`=1. Stays until `mem_ready`, then FETCH.
- EXEC: src_a=1, src_b=00. alu_ctrl from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct → HALT, with no register write.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01. `pc_en` = `zero`.
- ADDIEX: src_a=1, src_b=10, add. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
- JUMP: pc_src=10, pc_en=1.
- HALT: all enables 0, `illegal`=1. Only `rst` exits.
- `pc_en` = (FETCH & mem_ready) | BRANCH&zero | JUMP.
- Final states are MEMWB, MEMWR (on ready), ALUWB, BRANCH, ADDIWB and JUMP. Each returns to FETCH and increments `retired`, which wraps modulo 2^CNT_W.
- Unlisted selects are 0; alu_ctrl defaults to 010.

## Timing
- Outputs are combinational from the state register plus `mem_ready`/`zero`/funct. There is no output register.
- Reset: state=FETCH, `retired`=0, `illegal`=0. While `rst`=1, all write enables and `mem_read` are forced to 0.
- Cycles per instruction with `mem_ready` held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle, with that state's outputs held.
- `rst` asserted mid-instruction aborts it on the next edge: no write, no count.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Configuration
- `MIPS_MC_BNE_EN` defined: opcode 000101 decodes in DECODE to state BNE.
  - BNE outputs match BRANCH except `pc_en` = ~`zero`.
  - 3 cycles; retires like beq.
- Not defined: opcode 000101 → HALT with `illegal`=1.

## Test plan
- Reset, then `mem_ready`=1 and addi 0x2010D08E: FETCH→DECODE→ADDIEX→ADDIWB→FETCH.
  - ADDIWB shows reg_write=1, reg_dst=0.
  - `retired`=1 after 4 cycles.
- lw 0x8C100004 with `mem_ready` low for 2 cycles in MEMRD: completes in 7 cycles.
  - mem_read=1 and iord=1 held throughout MEMRD.
  - Exactly one reg_write pulse, with mem_to_reg=1.
- add 0x02328020 → alu_ctrl=010 in EXEC. funct 0x2A → 111. Funct 0x3F → HALT, `illegal`=1, no reg_write; stays until rst.
- beq 0x12110002 with zero=1 → pc_en=1 and pc_src=01 in BRANCH. With zero=0 → pc_en=0. Both take 3 cycles.
- j 0x08000010 → pc_src=10, pc_en=1 in cycle 3. Then `rst` asserted during MEMADR of an sw → state FETCH, no mem_write, `retired`=0.
- Opcode 000101 with zero=0:
  - Macro defined → pc_en=1 in BNE.
  - Macro undefined → HALT, `illegal`=1.
